// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-ready timeout.
// Optional performance counters are built when MULTICYCLE_PERF_EN is defined.
module multicycle_control_fsm #(
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic [5:0]       Funct,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic [1:0]       PCSrc,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemAddrSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALUOP,
   output logic             SignImm,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       RegDataSrc,
   output logic [2:0]       State,
   output logic             InstrDone,
   output logic             IllegalInstr,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] CycleCnt,
   output logic [CNT_W-1:0] RetireCnt
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_OR  = 3'd2,
      ALU_LUI = 3'd3
   } alu_op_t;

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_wait;
   alu_op_t           w_aluop;

   logic w_pcwrite, w_irwrite, w_memread, w_memwrite, w_regwrite;
   logic w_done, w_illegal, w_timeout;

   logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_jal, w_legal;
   logic w_wait_hit;

   assign w_rtype = (Opcode == 6'b000000);
   assign w_addu  = w_rtype && (Funct == 6'b100001);
   assign w_subu  = w_rtype && (Funct == 6'b100011);
   assign w_jr    = w_rtype && (Funct == 6'b001000);
   assign w_ori   = (Opcode == 6'b001101);
   assign w_lw    = (Opcode == 6'b100011);
   assign w_sw    = (Opcode == 6'b101011);
   assign w_beq   = (Opcode == 6'b000100);
   assign w_lui   = (Opcode == 6'b001111);
   assign w_jal   = (Opcode == 6'b000011);
   assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lw | w_sw | w_beq | w_lui | w_jal;

   assign w_wait_hit = (r_wait == WAIT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
      w_next     = r_state;
      w_pcwrite  = 1'b0;
      w_irwrite  = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_regwrite = 1'b0;
      w_done     = 1'b0;
      w_illegal  = 1'b0;
      w_timeout  = 1'b0;
      PCSrc      = 2'd0;
      MemAddrSrc = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'd0;
      w_aluop    = ALU_ADD;
      SignImm    = 1'b0;
      RegDst     = 2'd0;
      RegDataSrc = 2'd0;
      case (r_state)
         S_FETCH: begin
            w_memread = 1'b1;
            ALUSrcB   = 2'd1;
            if (MemReady) begin
               w_irwrite = 1'b1;
               w_pcwrite = 1'b1;
               w_next    = S_DECODE;
            end else if (w_wait_hit) begin
               w_timeout = 1'b1;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'd3;
            SignImm = 1'b1;
            if (w_jal) begin
               w_regwrite = 1'b1;
               RegDst     = 2'd2;
               RegDataSrc = 2'd2;
               w_pcwrite  = 1'b1;
               PCSrc      = 2'd2;
               w_done     = 1'b1;
               w_next     = S_FETCH;
            end else if (w_jr) begin
               w_pcwrite = 1'b1;
               PCSrc     = 2'd3;
               w_done    = 1'b1;
               w_next    = S_FETCH;
            end else if (!w_legal) begin
               w_illegal = 1'b1;
               w_next    = S_FETCH;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            w_next  = S_WB;
            if (w_addu || w_subu) begin
               w_aluop = w_subu ? ALU_SUB : ALU_ADD;
            end else if (w_ori) begin
               ALUSrcB = 2'd2;
               w_aluop = ALU_OR;
            end else if (w_lui) begin
               ALUSrcB = 2'd2;
               w_aluop = ALU_LUI;
            end else if (w_lw || w_sw) begin
               ALUSrcB = 2'd2;
               SignImm = 1'b1;
               w_next  = S_MEM;
            end else begin
               // BEQ: the ALU compares rs and rt; the target was latched in DECODE
               w_aluop   = ALU_SUB;
               w_pcwrite = Zero;
               PCSrc     = 2'd1;
               w_done    = 1'b1;
               w_next    = S_FETCH;
            end
         end
         S_MEM: begin
            MemAddrSrc = 1'b1;
            w_memread  = w_lw;
            w_memwrite = w_sw;
            if (MemReady) begin
               w_done = w_sw;
               w_next = w_lw ? S_WB : S_FETCH;
            end else if (w_wait_hit) begin
               w_timeout = 1'b1;
               w_next    = S_FETCH;
            end
         end
         S_WB: begin
            w_regwrite = 1'b1;
            w_done     = 1'b1;
            RegDst     = w_rtype ? 2'd1 : 2'd0;
            RegDataSrc = w_lw ? 2'd1 : 2'd0;
            w_next     = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Wait counter only advances while stalled in FETCH/MEM; any transition or abort restarts it.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         r_state <= S_FETCH;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         if ((w_next != r_state) || w_timeout)
            r_wait <= '0;
         else if ((r_state == S_FETCH) || (r_state == S_MEM))
            r_wait <= r_wait + WAIT_W'(1);
      end
   end

   assign PCWrite      = w_pcwrite  & ~reset;
   assign IRWrite      = w_irwrite  & ~reset;
   assign MemRead      = w_memread  & ~reset;
   assign MemWrite     = w_memwrite & ~reset;
   assign RegWrite     = w_regwrite & ~reset;
   assign InstrDone    = w_done     & ~reset;
   assign IllegalInstr = w_illegal  & ~reset;
   assign MemTimeout   = w_timeout  & ~reset;
   assign ALUOP        = w_aluop;
   assign State        = r_state;

`ifdef MULTICYCLE_PERF_EN
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_retire_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_cnt  <= '0;
         r_retire_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (InstrDone)
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
   end

   assign CycleCnt  = r_cycle_cnt;
   assign RetireCnt = r_retire_cnt;
`else
   assign CycleCnt  = '0;
   assign RetireCnt = '0;
`endif

endmodule
